// File: rtl/alsu_pkg.sv
// rtl/alsu_pkg.sv - shared command layout, widths and FSM encoding for the ALSU operand driver
package alsu_pkg;

    localparam int CMD_W  = 16;
    localparam int OUT_W  = 6;
    localparam int LEDS_W = 16;

    localparam int A_MSB      = 15;
    localparam int A_LSB      = 13;
    localparam int B_MSB      = 12;
    localparam int B_LSB      = 10;
    localparam int OP_MSB     = 9;
    localparam int OP_LSB     = 7;
    localparam int CIN_BIT    = 6;
    localparam int SERIAL_BIT = 5;
    localparam int DIR_BIT    = 4;
    localparam int RED_A_BIT  = 3;
    localparam int RED_B_BIT  = 2;
    localparam int BYP_A_BIT  = 1;
    localparam int BYP_B_BIT  = 0;

    typedef struct packed {
        logic [2:0] a;
        logic [2:0] b;
        logic [2:0] opcode;
        logic       cin;
        logic       serial_in;
        logic       diraction;
        logic       red_op_a;
        logic       red_op_b;
        logic       bypass_a;
        logic       bypass_b;
    } alsu_cmd_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } drv_state_e;

    function automatic alsu_cmd_t unpack_cmd(input logic [CMD_W-1:0] raw);
        alsu_cmd_t c;
        c.a         = raw[A_MSB:A_LSB];
        c.b         = raw[B_MSB:B_LSB];
        c.opcode    = raw[OP_MSB:OP_LSB];
        c.cin       = raw[CIN_BIT];
        c.serial_in = raw[SERIAL_BIT];
        c.diraction = raw[DIR_BIT];
        c.red_op_a  = raw[RED_A_BIT];
        c.red_op_b  = raw[RED_B_BIT];
        c.bypass_a  = raw[BYP_A_BIT];
        c.bypass_b  = raw[BYP_B_BIT];
        return c;
    endfunction

endpackage

// File: rtl/alsu_cmd_fifo.sv
// rtl/alsu_cmd_fifo.sv - synchronous command FIFO with full/empty flags
module alsu_cmd_fifo
    import alsu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = CMD_W
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign rdata_o = mem_q[rd_ptr_q];

    // Storage is not reset; only pointers and count define validity.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + CNT_W'(1);
            end else if (do_pop && !do_push) begin
                count_q <= count_q - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/alsu_op_driver.sv
// rtl/alsu_op_driver.sv - queues ALSU commands, drives them onto the ALSU pins and returns tagged results
module alsu_op_driver
    import alsu_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int ALSU_LAT   = 2,
    parameter int SEQ_W      = 4
) (
    input  logic              CLK,
    input  logic              RST_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [CMD_W-1:0]  cmd_data,
    output logic [2:0]        alsu_A,
    output logic [2:0]        alsu_B,
    output logic [2:0]        alsu_opcode,
    output logic              alsu_cin,
    output logic              alsu_serial_in,
    output logic              alsu_diraction,
    output logic              alsu_red_op_A,
    output logic              alsu_red_op_B,
    output logic              alsu_bypass_A,
    output logic              alsu_bypass_B,
    input  logic [OUT_W-1:0]  alsu_out,
    input  logic [LEDS_W-1:0] alsu_leds,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [OUT_W-1:0]  rsp_out,
    output logic              rsp_invalid,
    output logic [SEQ_W-1:0]  rsp_seq,
    output logic              busy
);

    localparam int CNT_W = $clog2(ALSU_LAT + 1);

    drv_state_e       state_q;
    alsu_cmd_t        drv_q;
    logic [CNT_W-1:0] cnt_q;
    logic             acc_q;
    logic [SEQ_W-1:0] seq_q;
    logic             rsp_valid_q;
    logic [OUT_W-1:0] rsp_out_q;
    logic             rsp_invalid_q;
    logic [SEQ_W-1:0] rsp_seq_q;

    logic [CMD_W-1:0] fifo_rdata;
    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_push;
    logic             fifo_pop;
    logic             leds_any;
    alsu_cmd_t        head_cmd;

    assign cmd_ready = !fifo_full;
    assign fifo_push = cmd_valid && !fifo_full;
    assign fifo_pop  = (state_q == ST_IDLE) && !fifo_empty;
    assign head_cmd  = unpack_cmd(fifo_rdata);
    assign leds_any  = |alsu_leds;

    alsu_cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (CMD_W)
    ) u_cmd_fifo (
        .clk_i   (CLK),
        .rst_ni  (RST_n),
        .push_i  (fifo_push),
        .wdata_i (cmd_data),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // The ALSU result is taken on the last wait cycle; the live leds value of
    // that same cycle is folded into the invalid flag along with the history.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state_q       <= ST_IDLE;
            drv_q         <= '0;
            cnt_q         <= '0;
            acc_q         <= 1'b0;
            seq_q         <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_out_q     <= '0;
            rsp_invalid_q <= 1'b0;
            rsp_seq_q     <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        drv_q   <= head_cmd;
                        cnt_q   <= CNT_W'(ALSU_LAT);
                        acc_q   <= 1'b0;
                        state_q <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    acc_q <= acc_q | leds_any;
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        rsp_out_q     <= alsu_out;
                        rsp_invalid_q <= acc_q | leds_any;
                        rsp_seq_q     <= seq_q;
                        seq_q         <= seq_q + SEQ_W'(1);
                        rsp_valid_q   <= 1'b1;
                        state_q       <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign alsu_A         = drv_q.a;
    assign alsu_B         = drv_q.b;
    assign alsu_opcode    = drv_q.opcode;
    assign alsu_cin       = drv_q.cin;
    assign alsu_serial_in = drv_q.serial_in;
    assign alsu_diraction = drv_q.diraction;
    assign alsu_red_op_A  = drv_q.red_op_a;
    assign alsu_red_op_B  = drv_q.red_op_b;
    assign alsu_bypass_A  = drv_q.bypass_a;
    assign alsu_bypass_B  = drv_q.bypass_b;

    assign rsp_valid   = rsp_valid_q;
    assign rsp_out     = rsp_out_q;
    assign rsp_invalid = rsp_invalid_q;
    assign rsp_seq     = rsp_seq_q;
    assign busy        = (state_q != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_alsu_op_driver.sv
// tb/tb_alsu_op_driver.sv - directed self-checking bench for alsu_op_driver with a stand-in ALSU
module tb_alsu_op_driver;
    import alsu_pkg::*;

    localparam int ALSU_LAT = 2;
    localparam int SEQ_W    = 4;

    logic              clk;
    logic              rst_n;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [CMD_W-1:0]  cmd_data;
    logic [2:0]        alsu_A, alsu_B, alsu_opcode;
    logic              alsu_cin, alsu_serial_in, alsu_diraction;
    logic              alsu_red_op_A, alsu_red_op_B, alsu_bypass_A, alsu_bypass_B;
    logic [OUT_W-1:0]  alsu_out;
    logic [LEDS_W-1:0] alsu_leds;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [OUT_W-1:0]  rsp_out;
    logic              rsp_invalid;
    logic [SEQ_W-1:0]  rsp_seq;
    logic              busy;

    int n_cmp  = 0;
    int n_fail = 0;

    alsu_op_driver #(.FIFO_DEPTH(4), .ALSU_LAT(ALSU_LAT), .SEQ_W(SEQ_W)) dut (
        .CLK(clk), .RST_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data),
        .alsu_A(alsu_A), .alsu_B(alsu_B), .alsu_opcode(alsu_opcode),
        .alsu_cin(alsu_cin), .alsu_serial_in(alsu_serial_in), .alsu_diraction(alsu_diraction),
        .alsu_red_op_A(alsu_red_op_A), .alsu_red_op_B(alsu_red_op_B),
        .alsu_bypass_A(alsu_bypass_A), .alsu_bypass_B(alsu_bypass_B),
        .alsu_out(alsu_out), .alsu_leds(alsu_leds),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_out(rsp_out),
        .rsp_invalid(rsp_invalid), .rsp_seq(rsp_seq), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Combinational stand-in for the ALSU: invalid ops light all leds and zero the output.
    always_comb begin
        logic       inv;
        logic [5:0] cat;
        cat       = {alsu_A, alsu_B};
        inv       = (alsu_opcode[2:1] == 2'b11) ||
                    ((alsu_red_op_A || alsu_red_op_B) && alsu_opcode[2:1] != 2'b00);
        alsu_leds = inv ? 16'hFFFF : 16'h0000;
        alsu_out  = '0;
        if (!inv) begin
            if (alsu_bypass_A)      alsu_out = {3'b0, alsu_A};
            else if (alsu_bypass_B) alsu_out = {3'b0, alsu_B};
            else begin
                case (alsu_opcode)
                    3'b000: alsu_out = alsu_red_op_A ? {5'b0, &alsu_A} :
                                       alsu_red_op_B ? {5'b0, &alsu_B} : {3'b0, alsu_A & alsu_B};
                    3'b001: alsu_out = alsu_red_op_A ? {5'b0, ^alsu_A} :
                                       alsu_red_op_B ? {5'b0, ^alsu_B} : {3'b0, alsu_A ^ alsu_B};
                    3'b010: alsu_out = {3'b0, alsu_A} + {3'b0, alsu_B} + {5'b0, alsu_cin};
                    3'b011: alsu_out = {3'b0, alsu_A} * {3'b0, alsu_B};
                    3'b100: alsu_out = alsu_diraction ? {cat[4:0], alsu_serial_in}
                                                      : {alsu_serial_in, cat[5:1]};
                    default: alsu_out = alsu_diraction ? {cat[4:0], cat[5]} : {cat[0], cat[5:1]};
                endcase
            end
        end
    end

    typedef struct {
        logic [15:0] cmd;
        logic [5:0]  exp_out;
        logic        exp_inv;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_cmd(input logic [15:0] c);
        int guard;
        cmd_data  = c;
        cmd_valid = 1'b1;
        guard     = 0;
        while (!cmd_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) check("push_timeout", 32'd1, 32'd0);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    // Called right after the push edge's following negedge (cycle 1 after push).
    task automatic wait_rsp(output int cycles);
        cycles = 1;
        while (!rsp_valid && cycles < 60) begin
            @(negedge clk);
            cycles++;
        end
        if (!rsp_valid) check("rsp_timeout", 32'd1, 32'd0);
    endtask

    task automatic send_check(input string name, input logic [15:0] c, input logic [5:0] eo,
                              input logic ei, input logic [SEQ_W-1:0] es, input bit chk_lat);
        int cyc;
        push_cmd(c);
        wait_rsp(cyc);
        if (chk_lat) check({name, "_latency"}, cyc, ALSU_LAT + 2);
        check({name, "_out"}, rsp_out, eo);
        check({name, "_inv"}, rsp_invalid, ei);
        check({name, "_seq"}, rsp_seq, es);
        @(negedge clk);
    endtask

    initial begin
        int          cyc;
        bit          saw_full;
        bit          stable_ok;
        bit          spurious;
        int          got;

        vecs[0] = '{16'hEC00, 6'b000011, 1'b0};
        vecs[1] = '{16'hED00, 6'b001010, 1'b0};
        vecs[2] = '{16'hED08, 6'b000000, 1'b1};
        vecs[3] = '{16'hEF00, 6'b000000, 1'b1};
        vecs[4] = '{16'hEC00, 6'b000011, 1'b0};
        vecs[5] = '{16'hAC80, 6'b000110, 1'b0};
        vecs[6] = '{16'hF980, 6'b101010, 1'b0};
        vecs[7] = '{16'hA940, 6'b001000, 1'b0};
        vecs[8] = '{16'h8C02, 6'b000100, 1'b0};
        vecs[9] = '{16'hEF80, 6'b000000, 1'b1};

        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_data  = '0;
        rsp_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_rsp_seq", rsp_seq, 0);
        check("rst_alsu", {alsu_A, alsu_B, alsu_opcode, alsu_cin, alsu_serial_in, alsu_diraction,
                           alsu_red_op_A, alsu_red_op_B, alsu_bypass_A, alsu_bypass_B}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            send_check($sformatf("vec%0d", i), vecs[i].cmd, vecs[i].exp_out,
                       vecs[i].exp_inv, SEQ_W'(i), 1'b1);
        end
        check("alsu_held_idle_opcode", alsu_opcode, 3'b111);

        // Back-to-back burst after a fresh reset: FIFO must fill, responses in order.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n    = 1'b1;
        @(negedge clk);
        saw_full = 1'b0;
        got      = 0;
        fork
            begin
                for (int j = 0; j < 6; j++) begin
                    int guard;
                    cmd_data  = vecs[j].cmd;
                    cmd_valid = 1'b1;
                    guard     = 0;
                    while (!cmd_ready && guard < 100) begin
                        saw_full = 1'b1;
                        @(negedge clk);
                        guard++;
                    end
                    @(negedge clk);
                end
                cmd_valid = 1'b0;
            end
            begin
                for (int r = 0; r < 6; r++) begin
                    int w;
                    w = 0;
                    @(negedge clk);
                    while (!rsp_valid && w < 60) begin
                        @(negedge clk);
                        w++;
                    end
                    if (rsp_valid) begin
                        check($sformatf("burst%0d_out", r), rsp_out, vecs[r].exp_out);
                        check($sformatf("burst%0d_seq", r), rsp_seq, r);
                        got++;
                    end
                end
            end
        join
        check("burst_saw_full", saw_full, 1);
        check("burst_count", got, 6);
        repeat (2) @(negedge clk);

        // Backpressure: response held across 10 stalled cycles, queued command not popped.
        rsp_ready = 1'b0;
        push_cmd(vecs[6].cmd);
        push_cmd(vecs[7].cmd);
        wait_rsp(cyc);
        stable_ok = 1'b1;
        for (int k = 0; k < 10; k++) begin
            if (!(rsp_valid === 1'b1 && rsp_out === 6'b101010 && rsp_seq === 4'd6 &&
                  alsu_A === 3'b111 && alsu_opcode === 3'b011 && busy === 1'b1))
                stable_ok = 1'b0;
            @(negedge clk);
        end
        check("stall_stable", stable_ok, 1);
        rsp_ready = 1'b1;
        @(negedge clk);
        wait_rsp(cyc);
        check("stall_next_out", rsp_out, 6'b001000);
        check("stall_next_seq", rsp_seq, 7);
        @(negedge clk);

        // Reset during WAIT with three commands still queued.
        rsp_ready = 1'b0;
        push_cmd(vecs[0].cmd);
        wait_rsp(cyc);
        check("pre_reset_seq", rsp_seq, 8);
        for (int j = 1; j <= 4; j++) push_cmd(vecs[j].cmd);
        check("fifo_full_ready", cmd_ready, 0);
        rsp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("in_wait_busy", busy, 1);
        check("in_wait_opcode", alsu_opcode, 3'b010);
        rst_n = 1'b0;
        #1;
        check("midrst_rsp_valid", rsp_valid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_cmd_ready", cmd_ready, 1);
        check("midrst_alsu_opcode", alsu_opcode, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n    = 1'b1;
        spurious = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0 || busy !== 1'b0) spurious = 1'b1;
        end
        check("post_reset_quiet", spurious, 0);
        send_check("post_reset", vecs[1].cmd, 6'b001010, 1'b0, 4'd0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got expired expected finish");
        $fatal(1);
    end

endmodule
